sys_trace_monitor: RTL and testbench
====================================

SYS_TRACE_MONITOR -- requirements
Module: sys_trace_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, width of each observed channel
- NUM_CH, 8, number of observed channels; channel 0 is the PC
- DEPTH, 16, trace entries (power of two, >=2)
- POST_TRIG, 4, entries captured after the trigger entry (0..DEPTH-1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- SYS_clk, in, 1, sole clock, rising edge
- SYS_reset, in, 1, asynchronous active-low reset
- ch_data, in, NUM_CH*DATA_W, flattened channels; ch k = bits [k*DATA_W +: DATA_W]
- ch_valid, in, 1, one-cycle commit strobe per retired instruction
- mode, in, 2, 0 LIVE, 1 TRACE, 2 REPLAY, 3 STEP
- out_sel, in, 4, channel select for SYS_leds
- rd_idx, in, log2(DEPTH), replay entry index, 0 = oldest
- trig_en, in, 1, arm the PC-match trigger
- trig_pc, in, DATA_W, trigger PC value
- clear, in, 1, synchronous clear of trace state
- step, in, 1, single-step request level
- SYS_leds, out, DATA_W, registered display value
- out_PC, out, DATA_W, registered channel 0
- trig_hit, out, 1, sticky trigger-matched flag
- buf_full, out, 1, high when stored count == DEPTH
- cpu_stall, out, 1, processor hold request

Function
REQ-003 out_PC SHALL register ch 0 every cycle in all modes.
REQ-004 LIVE/TRACE/STEP: SYS_leds SHALL register ch[out_sel] one cycle after sampling; out_sel >= NUM_CH SHALL hold the previous SYS_leds value.
REQ-005 REPLAY: SYS_leds SHALL register ch[out_sel] of entry (oldest + rd_idx) mod DEPTH; 1-cycle latency; rd_idx >= count or out_sel >= NUM_CH SHALL drive 0.
REQ-006 Capture FSM states SHALL be IDLE, ARMED, POST, FROZEN.
REQ-007 IDLE -> ARMED when mode == TRACE; any state -> IDLE when mode != TRACE, except FROZEN, which SHALL persist through REPLAY.
REQ-008 ARMED: each ch_valid SHALL write all channels at wr_ptr, increment wr_ptr mod DEPTH, and increment count, saturating at DEPTH; on overflow, oldest SHALL advance with wr_ptr.
REQ-009 ARMED, trig_en, ch_valid, ch0 == trig_pc: SHALL write the entry, set trig_hit, load post_cnt = POST_TRIG, then go to POST, or directly to FROZEN when POST_TRIG == 0.
REQ-010 POST: each ch_valid SHALL write and decrement post_cnt; the write that takes post_cnt to 0 SHALL enter FROZEN.
REQ-011 FROZEN: no writes; triggers ignored; exits only on clear or mode == LIVE/STEP.
REQ-012 clear SHALL zero wr_ptr, count, post_cnt and trig_hit, and go to IDLE; clear together with ch_valid SHALL win (no write).
REQ-013 Leaving TRACE mid-POST SHALL retain buffer contents and count; trig_hit SHALL stay set until clear.
REQ-014 STEP: cpu_stall SHALL be 1 except for exactly one cycle following each 0->1 edge of step (registered edge detect); other modes SHALL drive cpu_stall = 0.
REQ-015 buf_full SHALL be registered from count == DEPTH.

Reset
REQ-016 SYS_reset low SHALL immediately force SYS_leds = 0, out_PC = 0, trig_hit = 0, buf_full = 0, cpu_stall = 0, state = IDLE, and wr_ptr, count, post_cnt and step edge register = 0; trace memory contents SHALL be don't-care.
REQ-017 Reset asserted mid-POST SHALL abandon capture with no further writes.

Structure
REQ-018 Package sys_dbg_pkg SHALL hold the mode encodings, the capture state enum and the default parameter values.
REQ-019 Storage SHALL be the sub-module trace_ram: DEPTH x (NUM_CH*DATA_W), synchronous write, asynchronous read.

Verification
REQ-020 LIVE, out_sel = 2, ch2 = 0x1234ABCD -> SYS_leds = 0x1234ABCD next cycle; out_sel = 9 -> value held.
REQ-021 TRACE, 20 commits with PC = 0,4,...,76, DEPTH = 16 -> buf_full = 1; REPLAY rd_idx = 0, out_sel = 0 -> SYS_leds = 16; rd_idx = 15 -> 76.
REQ-022 trig_pc = 0x40, POST_TRIG = 4, PCs 0x30..0x70 step 4 -> trig_hit at 0x40; FROZEN after 0x50; later commits not stored.
REQ-023 clear and ch_valid in the same cycle with count = 3 -> count = 0, trig_hit = 0, no write.
REQ-024 STEP, step toggled 0->1 twice -> exactly two single-cycle cpu_stall = 0 windows; step held high -> one window only.
REQ-025 SYS_reset pulsed low during POST -> all outputs 0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/sys_trace_monitor_pkg.sv
// ---------------------------------------------------------------------------
// sys_dbg_pkg
// Shared definitions for the system trace monitor:
//   - mode_e      : operating mode encoding driven on the 2-bit mode input
//   - cap_state_e : capture FSM states
//   - DEF_*       : default parameter values used by the interface and top
// ---------------------------------------------------------------------------
package sys_dbg_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'd0,
    MODE_TRACE  = 2'd1,
    MODE_REPLAY = 2'd2,
    MODE_STEP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } cap_state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_POST_TRIG = 4;

endpackage

// File: rtl/sys_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// sys_trace_monitor_if
// Bundles the observed processor channels, the debug controls and the
// monitor's display/status outputs.
//   master : the observed system / debug host (drives channels and controls)
//   slave  : the trace monitor (drives SYS_leds, out_PC, status, cpu_stall)
// Signals:
//   ch_data   flattened channels, ch k = ch_data[k*DATA_W +: DATA_W]
//   ch_valid  one-cycle commit strobe per retired instruction
//   mode      LIVE / TRACE / REPLAY / STEP
//   out_sel   channel select for SYS_leds
//   rd_idx    replay index, 0 = oldest stored entry
//   trig_en   arm PC-match trigger, trig_pc = PC to match
//   clear     synchronous clear of trace state
//   step      single-step request level
//   SYS_leds  registered display value, out_PC registered channel 0
//   trig_hit  sticky trigger flag, buf_full buffer holds DEPTH entries
//   cpu_stall processor hold request
// ---------------------------------------------------------------------------
interface sys_trace_monitor_if
  import sys_dbg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH
);
  logic [NUM_CH*DATA_W-1:0]  ch_data;
  logic                      ch_valid;
  logic [1:0]                mode;
  logic [3:0]                out_sel;
  logic [$clog2(DEPTH)-1:0]  rd_idx;
  logic                      trig_en;
  logic [DATA_W-1:0]         trig_pc;
  logic                      clear;
  logic                      step;
  logic [DATA_W-1:0]         SYS_leds;
  logic [DATA_W-1:0]         out_PC;
  logic                      trig_hit;
  logic                      buf_full;
  logic                      cpu_stall;

  modport master (
    output ch_data, ch_valid, mode, out_sel, rd_idx, trig_en, trig_pc,
           clear, step,
    input  SYS_leds, out_PC, trig_hit, buf_full, cpu_stall
  );

  modport slave (
    input  ch_data, ch_valid, mode, out_sel, rd_idx, trig_en, trig_pc,
           clear, step,
    output SYS_leds, out_PC, trig_hit, buf_full, cpu_stall
  );
endinterface

// File: rtl/sys_trace_monitor_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
// DEPTH x WIDTH trace storage: synchronous write, asynchronous read.
// Contents are not reset.
//   clk      write clock (rising edge)
//   we_i     write enable, waddr_i / wdata_i write port
//   raddr_i  combinational read address, rdata_o read data
// ---------------------------------------------------------------------------
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sys_trace_monitor.sv
// ---------------------------------------------------------------------------
// sys_trace_monitor
// Observes NUM_CH processor channels (channel 0 = PC), shows a selected
// channel on SYS_leds, records committed instructions into a circular
// trace buffer with a PC-match trigger and post-trigger window, replays
// stored entries, and single-steps the processor via cpu_stall.
// Ports:
//   SYS_clk    sole clock, rising edge
//   SYS_reset  asynchronous active-low reset
//   bus        sys_trace_monitor_if.slave (channels, controls, outputs)
// ---------------------------------------------------------------------------
module sys_trace_monitor
  import sys_dbg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int POST_TRIG = DEF_POST_TRIG
) (
  input logic                SYS_clk,
  input logic                SYS_reset,
  sys_trace_monitor_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(NUM_CH);
  localparam int ROW_W = NUM_CH * DATA_W;
  localparam int CNT_W = AW + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [AW-1:0]    POST_LOAD = AW'(POST_TRIG);

  // Channel views
  logic [NUM_CH-1:0][DATA_W-1:0] ch_w;
  logic [NUM_CH-1:0][DATA_W-1:0] rd_row;
  mode_e                         mode;
  logic [CW-1:0]                 sel;
  logic                          sel_ok;

  assign ch_w   = bus.ch_data;
  assign mode   = mode_e'(bus.mode);
  assign sel    = bus.out_sel[CW-1:0];
  assign sel_ok = int'(bus.out_sel) < NUM_CH;

  // Capture state
  cap_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    post_cnt_q, post_cnt_d;
  logic             trig_hit_q, trig_hit_d;
  logic             buf_full_q, buf_full_d;
  logic             we;

  // Display / step registers
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [DATA_W-1:0] pc_q;
  logic              step_q;
  logic              stall_q, stall_d;

  // Oldest entry is implied by wr_ptr and count: while filling it is slot 0,
  // once full (count[AW-1:0] wraps to 0) it tracks wr_ptr.
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic          rd_ok;

  assign oldest  = wr_ptr_q - count_q[AW-1:0];
  assign rd_addr = oldest + bus.rd_idx;
  assign rd_ok   = {1'b0, bus.rd_idx} < count_q;

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ROW_W)
  ) u_ram (
    .clk     (SYS_clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ch_w),
    .raddr_i (rd_addr),
    .rdata_o (rd_row)
  );

  // Capture next-state
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    trig_hit_d = trig_hit_q;
    we         = 1'b0;

    if (bus.clear) begin
      // clear beats a same-cycle commit
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      trig_hit_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode == MODE_TRACE) state_d = ST_ARMED;
        end
        ST_ARMED, ST_POST: begin
          if (mode != MODE_TRACE) begin
            state_d = ST_IDLE;
          end else if (bus.ch_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL_CNT) count_d = count_q + 1'b1;
            if (state_q == ST_ARMED) begin
              if (bus.trig_en && (ch_w[0] == bus.trig_pc)) begin
                trig_hit_d = 1'b1;
                post_cnt_d = POST_LOAD;
                state_d    = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
              end
            end else begin
              post_cnt_d = post_cnt_q - 1'b1;
              if (post_cnt_q <= AW'(1)) state_d = ST_FROZEN;
            end
          end
        end
        ST_FROZEN: begin
          // persists through TRACE and REPLAY
          if (mode == MODE_LIVE || mode == MODE_STEP) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    buf_full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      trig_hit_q <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      trig_hit_q <= trig_hit_d;
      buf_full_q <= buf_full_d;
    end
  end

  // Display and single-step
  always_comb begin
    leds_d = leds_q;
    if (mode == MODE_REPLAY) begin
      leds_d = (sel_ok && rd_ok) ? rd_row[sel] : '0;
    end else if (sel_ok) begin
      leds_d = ch_w[sel];
    end
    // stall released for one cycle after each rising edge of step
    stall_d = (mode == MODE_STEP) && !(bus.step && !step_q);
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      leds_q  <= '0;
      pc_q    <= '0;
      step_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      pc_q    <= ch_w[0];
      step_q  <= bus.step;
      stall_q <= stall_d;
    end
  end

  assign bus.SYS_leds  = leds_q;
  assign bus.out_PC    = pc_q;
  assign bus.trig_hit  = trig_hit_q;
  assign bus.buf_full  = buf_full_q;
  assign bus.cpu_stall = stall_q;

endmodule

// File: tb/tb_sys_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_sys_trace_monitor
// Directed stimulus pushes hand-computed expectations into a scoreboard
// queue; a monitor on the falling edge pops and compares them against the
// DUT outputs.
// ---------------------------------------------------------------------------
module tb_sys_trace_monitor;
  import sys_dbg_pkg::*;

  localparam int DATA_W    = 32;
  localparam int NUM_CH    = 8;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;

  typedef enum int {K_LEDS, K_PC, K_HIT, K_FULL, K_STALL} chk_e;
  typedef struct {
    string             name;
    chk_e              kind;
    logic [DATA_W-1:0] val;
  } exp_t;

  logic SYS_clk   = 1'b0;
  logic SYS_reset = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  sys_trace_monitor_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

  sys_trace_monitor #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // ---------------- monitor ----------------
  always @(negedge SYS_clk) begin
    while (sb_q.size() != 0) begin
      exp_t              e;
      logic [DATA_W-1:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_LEDS:  act = bus.SYS_leds;
        K_PC:    act = bus.out_PC;
        K_HIT:   act = {{(DATA_W-1){1'b0}}, bus.trig_hit};
        K_FULL:  act = {{(DATA_W-1){1'b0}}, bus.buf_full};
        default: act = {{(DATA_W-1){1'b0}}, bus.cpu_stall};
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", e.name, act, e.val);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [NUM_CH*DATA_W-1:0] mk(input logic [DATA_W-1:0] pc);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = (DATA_W'(k) << 24) | pc;
    return r;
  endfunction

  task automatic expect_v(input string nm, input chk_e k, input logic [DATA_W-1:0] v);
    exp_t e;
    e.name = nm; e.kind = k; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge SYS_clk); #1;
    end
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d checks pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge SYS_clk); #1;
  endtask

  task automatic commit(input logic [DATA_W-1:0] pc);
    bus.ch_data  = mk(pc);
    bus.ch_valid = 1'b1;
    tick();
    bus.ch_valid = 1'b0;
  endtask

  task automatic start_trace();
    bus.clear = 1'b1;
    bus.mode  = MODE_TRACE;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  task automatic replay_chk(input string nm, input logic [3:0] rd, input logic [3:0] sel,
                            input logic [DATA_W-1:0] v);
    bus.mode    = MODE_REPLAY;
    bus.rd_idx  = rd;
    bus.out_sel = sel;
    tick();
    expect_v(nm, K_LEDS, v);
    drain();
  endtask

  // ---------------- stimulus ----------------
  logic [NUM_CH*DATA_W-1:0] d;
  logic                     step_seq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic                     stall_exp[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    bus.ch_data  = '0;
    bus.ch_valid = 1'b0;
    bus.mode     = MODE_LIVE;
    bus.out_sel  = 4'd0;
    bus.rd_idx   = '0;
    bus.trig_en  = 1'b0;
    bus.trig_pc  = '0;
    bus.clear    = 1'b0;
    bus.step     = 1'b0;

    // reset state
    bus.ch_data = mk(32'h55);
    tick(); tick();
    expect_v("rst_leds",  K_LEDS,  32'h0);
    expect_v("rst_pc",    K_PC,    32'h0);
    expect_v("rst_hit",   K_HIT,   32'h0);
    expect_v("rst_full",  K_FULL,  32'h0);
    expect_v("rst_stall", K_STALL, 32'h0);
    drain();
    SYS_reset = 1'b1;

    // LIVE display
    d = mk(32'h100);
    d[2*DATA_W +: DATA_W] = 32'h1234ABCD;
    bus.ch_data = d;
    bus.out_sel = 4'd2;
    tick();
    expect_v("live_sel2", K_LEDS, 32'h1234ABCD);
    expect_v("live_pc",   K_PC,   32'h100);
    drain();
    d[2*DATA_W +: DATA_W] = 32'h0BAD0BAD;
    bus.ch_data = d;
    bus.out_sel = 4'd9;
    tick();
    expect_v("live_sel9_hold", K_LEDS, 32'h1234ABCD);
    drain();
    bus.out_sel = 4'd7;
    tick();
    expect_v("live_sel7", K_LEDS, 32'h07000100);
    drain();

    // STEP: two single pulses then one long high level
    bus.mode = MODE_STEP;
    tick();
    expect_v("step_enter", K_STALL, 32'h1);
    drain();
    for (int i = 0; i < 8; i++) begin
      bus.step = step_seq[i];
      tick();
      expect_v($sformatf("step_seq%0d", i), K_STALL, {31'b0, stall_exp[i]});
      drain();
    end
    bus.mode = MODE_LIVE;
    tick();
    expect_v("step_exit", K_STALL, 32'h0);
    drain();

    // TRACE overflow: 20 commits into 16 entries
    bus.out_sel = 4'd0;
    start_trace();
    for (int i = 0; i < 20; i++) commit(DATA_W'(4 * i));
    expect_v("fill_full", K_FULL, 32'h1);
    expect_v("fill_hit",  K_HIT,  32'h0);
    drain();
    replay_chk("replay_oldest", 4'd0,  4'd0, 32'd16);
    replay_chk("replay_newest", 4'd15, 4'd0, 32'd76);
    replay_chk("replay_ch5",    4'd3,  4'd5, 32'h0500001C);
    replay_chk("replay_sel8",   4'd3,  4'd8, 32'h0);

    // Trigger at 0x40 with 4 post-trigger entries
    bus.out_sel = 4'd0;
    start_trace();
    bus.trig_en = 1'b1;
    bus.trig_pc = 32'h40;
    for (int pc = 'h30; pc <= 'h70; pc += 4) begin
      commit(DATA_W'(pc));
      if (pc == 'h3C) begin expect_v("trig_before", K_HIT, 32'h0); drain(); end
      if (pc == 'h40) begin expect_v("trig_at40",   K_HIT, 32'h1); drain(); end
    end
    expect_v("trig_not_full", K_FULL, 32'h0);
    drain();
    replay_chk("trig_oldest",   4'd0, 4'd0, 32'h30);
    replay_chk("trig_last",     4'd8, 4'd0, 32'h50);
    replay_chk("trig_beyond",   4'd9, 4'd0, 32'h0);
    bus.mode = MODE_LIVE;
    tick();
    expect_v("trig_sticky", K_HIT, 32'h1);
    drain();

    // clear together with a commit
    start_trace();
    bus.trig_pc = 32'h108;
    commit(32'h100); commit(32'h104); commit(32'h108);
    expect_v("clr_pre_hit", K_HIT, 32'h1);
    drain();
    bus.ch_data  = mk(32'h200);
    bus.ch_valid = 1'b1;
    bus.clear    = 1'b1;
    tick();
    bus.ch_valid = 1'b0;
    bus.clear    = 1'b0;
    expect_v("clr_hit",  K_HIT,  32'h0);
    expect_v("clr_full", K_FULL, 32'h0);
    drain();
    replay_chk("clr_empty", 4'd0, 4'd0, 32'h0);
    bus.mode = MODE_TRACE;
    tick();
    commit(32'h300);
    replay_chk("clr_restart0", 4'd0, 4'd0, 32'h300);
    replay_chk("clr_restart1", 4'd1, 4'd0, 32'h0);

    // asynchronous reset during POST
    bus.out_sel = 4'd0;
    start_trace();
    bus.trig_pc = 32'h500;
    commit(32'h4FC); commit(32'h500); commit(32'h504);
    expect_v("post_hit",  K_HIT,  32'h1);
    expect_v("post_leds", K_LEDS, 32'h504);
    drain();
    bus.ch_data  = mk(32'h508);
    bus.ch_valid = 1'b1;
    @(posedge SYS_clk); #2;
    SYS_reset = 1'b0;
    expect_v("arst_leds",  K_LEDS,  32'h0);
    expect_v("arst_pc",    K_PC,    32'h0);
    expect_v("arst_hit",   K_HIT,   32'h0);
    expect_v("arst_full",  K_FULL,  32'h0);
    expect_v("arst_stall", K_STALL, 32'h0);
    drain();
    tick(); tick();
    SYS_reset    = 1'b1;
    bus.ch_valid = 1'b0;
    replay_chk("arst_empty", 4'd0, 4'd0, 32'h0);
    bus.mode = MODE_TRACE;
    tick();
    commit(32'h600);
    replay_chk("arst_recapture", 4'd0, 4'd0, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
